angle_to_iq: RTL and testbench



---
 rtl/angle_to_iq_if.sv | 19 +
 rtl/angle_to_iq.sv | 164 ++++++++++++++++
 tb/tb_angle_to_iq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/angle_to_iq_if.sv
// angle_to_iq_if: handshake and result bundle for angle_to_iq.
//   val_i   : angle_i valid; taken only while ready_o=1
//   angle_i : signed angle, radians x4096
//   ready_o : block idle, can accept
//   real_o  : signed AMP*cos(angle), held between results
//   imag_o  : signed AMP*sin(angle), held between results
//   val_o   : one-cycle pulse, real_o/imag_o updated
// The modport named slave is the block side; the modport named master is the requester side.
interface angle_to_iq_if;
  logic               val_i;
  logic signed [15:0] angle_i;
  logic               ready_o;
  logic signed [7:0]  real_o;
  logic signed [7:0]  imag_o;
  logic               val_o;

  modport slave  (input val_i, angle_i, output ready_o, real_o, imag_o, val_o);
  modport master (output val_i, angle_i, input ready_o, real_o, imag_o, val_o);
endinterface

// File: rtl/angle_to_iq.sv
// angle_to_iq: angle -> (AMP*cos, AMP*sin).
// Uses an iterative rotation-mode CORDIC with one micro-rotation per clock.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous reset, active high
//   bus        : angle_to_iq_if.slave (val_i/angle_i in, ready_o/real_o/imag_o/val_o out)
//   drop_cnt_o : saturating count of samples offered while busy (ANGLE_TO_IQ_DROP_CNT_EN only)
// Optional feature macro: ANGLE_TO_IQ_DROP_CNT_EN.
// Timing: a sample is accepted at edge E0; val_o goes high after edge E(ITER+1);
// the next sample can be accepted in the same cycle that val_o is high.
module angle_to_iq #(
  parameter int AMP  = 127,  // 1..127
  parameter int ITER = 12    // 8..12
) (
  input  logic         clk,
  input  logic         rst,
  angle_to_iq_if.slave bus
`ifdef ANGLE_TO_IQ_DROP_CNT_EN
  ,
  output logic [7:0]   drop_cnt_o
`endif
);

  // Starting vector length: AMP divided by the CORDIC gain, with 8 fractional bits.
  localparam int                 K_INT = (AMP * 159188 + 512) >>> 10;
  localparam logic signed [17:0] K     = 18'(K_INT);
  localparam logic signed [15:0] PI    = 16'sd12868;
  localparam logic signed [15:0] PI_2  = 16'sd6434;

  typedef enum logic [1:0] {IDLE, ROT, OUT} state_t;

  state_t             state, state_nxt;
  logic signed [17:0] x, y;
  logic signed [15:0] z;
  logic [3:0]         i;

  function automatic logic signed [15:0] atan_lut(input logic [3:0] k);
    case (k)
      4'd0:    return 16'sd3217;
      4'd1:    return 16'sd1899;
      4'd2:    return 16'sd1003;
      4'd3:    return 16'sd509;
      4'd4:    return 16'sd256;
      4'd5:    return 16'sd128;
      4'd6:    return 16'sd64;
      4'd7:    return 16'sd32;
      4'd8:    return 16'sd16;
      4'd9:    return 16'sd8;
      4'd10:   return 16'sd4;
      4'd11:   return 16'sd2;
      default: return 16'sd0;
    endcase
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [17:0] v);
    if (v > 18'sd127)       return 8'sh7f;
    else if (v < -18'sd127) return 8'sh81;
    else                    return v[7:0];
  endfunction

  // FSM
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.val_i) state_nxt = ROT;
      ROT:     if (i == 4'(ITER - 1)) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ready_o = (state == IDLE);

  // Clamp the angle to [-pi, pi].
  // Fold the outer quadrants by +/-pi/2 so that the residual angle lies
  // within the CORDIC convergence range.
  logic signed [15:0] a_clamp, z_pre;
  logic signed [17:0] x_pre, y_pre;
  always_comb begin
    a_clamp = bus.angle_i;
    if (bus.angle_i > PI)       a_clamp = PI;
    else if (bus.angle_i < -PI) a_clamp = -PI;
    z_pre = a_clamp;
    x_pre = K;
    y_pre = '0;
    if (a_clamp > PI_2) begin
      z_pre = a_clamp - PI_2;
      x_pre = '0;
      y_pre = K;
    end else if (a_clamp < -PI_2) begin
      z_pre = a_clamp + PI_2;
      x_pre = '0;
      y_pre = -K;
    end
  end

  // One micro-rotation; the rotation direction follows the sign of the residual angle.
  logic signed [17:0] xs, ys, x_rot, y_rot, x_rnd, y_rnd;
  logic signed [15:0] z_rot;
  always_comb begin
    xs = x >>> i;
    ys = y >>> i;
    if (z >= 16'sd0) begin
      x_rot = x - ys;
      y_rot = y + xs;
      z_rot = z - atan_lut(i);
    end else begin
      x_rot = x + ys;
      y_rot = y - xs;
      z_rot = z + atan_lut(i);
    end
    x_rnd = (x + 18'sd128) >>> 8;
    y_rnd = (y + 18'sd128) >>> 8;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x          <= '0;
      y          <= '0;
      z          <= '0;
      i          <= '0;
      bus.real_o <= '0;
      bus.imag_o <= '0;
      bus.val_o  <= 1'b0;
    end else begin
      bus.val_o <= 1'b0;
      case (state)
        IDLE: if (bus.val_i) begin
          x <= x_pre;
          y <= y_pre;
          z <= z_pre;
          i <= '0;
        end
        ROT: begin
          x <= x_rot;
          y <= y_rot;
          z <= z_rot;
          i <= i + 4'd1;
        end
        OUT: begin
          bus.real_o <= sat8(x_rnd);
          bus.imag_o <= sat8(y_rnd);
          bus.val_o  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef ANGLE_TO_IQ_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt_o <= '0;
    else if (bus.val_i && !bus.ready_o && drop_cnt_o != 8'hff)
      drop_cnt_o <= drop_cnt_o + 8'd1;
  end
`endif

endmodule

// File: tb/tb_angle_to_iq.sv
// tb_angle_to_iq: self-checking bench for angle_to_iq.
// Two instances run in lockstep: AMP=127 and AMP=64. Both use ITER=12.
// Expected I/Q values come from a floating-point cos/sin model with +/-1 LSB tolerance.
module tb_angle_to_iq;
  localparam int AMP  = 127;
  localparam int ITER = 12;
  localparam int LAT  = ITER + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  angle_to_iq_if bus();
  angle_to_iq_if bus64();

`ifdef ANGLE_TO_IQ_DROP_CNT_EN
  logic [7:0] drop_cnt, drop_cnt64;
`endif

  angle_to_iq #(.AMP(AMP), .ITER(ITER)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
`ifdef ANGLE_TO_IQ_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt)
`endif
  );

  angle_to_iq #(.AMP(64), .ITER(ITER)) dut64 (
    .clk(clk), .rst(rst), .bus(bus64.slave)
`ifdef ANGLE_TO_IQ_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt64)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
    checks++;
    if (got > exp + tol || got < exp - tol) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  // Reference model: clamp the angle, convert it to radians, and round amp*cos or amp*sin to the nearest integer.
  function automatic int model(input int a, input int amp, input bit is_sin);
    int  c;
    real th, v;
    c  = (a > 12868) ? 12868 : (a < -12868) ? -12868 : a;
    th = real'(c) / 4096.0;
    v  = is_sin ? real'(amp) * $sin(th) : real'(amp) * $cos(th);
    return int'(v);
  endfunction

  // Offer one sample to both instances. Check latency, ready_o behaviour, the single-cycle val_o pulse, and the results.
  task automatic run_one(input string tag, input logic signed [15:0] ang, input int er, input int ei);
    int n;
    bit seen, rdy_bad;
    chk({tag, ".rdy_in"}, int'(bus.ready_o), 1);
    bus.angle_i   = ang;
    bus.val_i     = 1'b1;
    bus64.angle_i = ang;
    bus64.val_i   = 1'b1;
    @(posedge clk); #1;
    bus.val_i   = 1'b0;
    bus64.val_i = 1'b0;
    n = 0; seen = 1'b0; rdy_bad = 1'b0;
    while (!seen && n < 40) begin
      if (bus.val_o) seen = 1'b1;
      else begin
        if (bus.ready_o) rdy_bad = 1'b1;
        @(posedge clk); #1;
        n++;
      end
    end
    chk({tag, ".lat"}, n, LAT);
    chk({tag, ".busy"}, int'(rdy_bad), 0);
    chk({tag, ".rdy_out"}, int'(bus.ready_o), 1);
    chk({tag, ".val64"}, int'(bus64.val_o), 1);
    chk({tag, ".re"}, int'(bus.real_o), er, 1);
    chk({tag, ".im"}, int'(bus.imag_o), ei, 1);
    chk({tag, ".re64"}, int'(bus64.real_o), model(int'(ang), 64, 1'b0), 1);
    chk({tag, ".im64"}, int'(bus64.imag_o), model(int'(ang), 64, 1'b1), 1);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, int'(bus.val_o), 0);
  endtask

  initial begin
    int pulses, first, second, n, gap;
    logic signed [15:0] a;

    rst = 1'b1;
    bus.val_i = 1'b0;   bus.angle_i = '0;
    bus64.val_i = 1'b0; bus64.angle_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", int'(bus.ready_o), 1);
    chk("rst.val",   int'(bus.val_o), 0);
    chk("rst.re",    int'(bus.real_o), 0);
    chk("rst.im",    int'(bus.imag_o), 0);
`ifdef ANGLE_TO_IQ_DROP_CNT_EN
    chk("rst.drop",  int'(drop_cnt), 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed angles; the expected values are derived by hand from cos/sin.
    run_one("a0",     16'sd0,      127,   0);
    run_one("pi2",    16'sd6434,     0, 127);
    run_one("pi",     16'sd12868, -127,   0);
    run_one("mpi",    -16'sd12868,-127,   0);
    run_one("mpi2",   -16'sd6434,    0,-127);
    run_one("pi4",    16'sd3217,    90,  90);
    run_one("m3pi4",  -16'sd9651,  -90, -90);
    run_one("clp_hi", 16'sd20000, -127,   0);
    run_one("clp_lo", -16'sd20000,-127,   0);

    // Hold val_i high: expect one result every ITER+2 clocks and drop the other samples.
    bus.angle_i = 16'sd1000;
    bus.val_i   = 1'b1;
    @(posedge clk); #1;
    pulses = 0; first = -1; second = -1;
    for (n = 0; n < 45; n++) begin
      if (bus.val_o) begin
        pulses++;
        if (first < 0) begin
          first = n;
`ifdef ANGLE_TO_IQ_DROP_CNT_EN
          chk("cont.drop", int'(drop_cnt), LAT);
`endif
        end else if (second < 0) second = n;
      end
      @(posedge clk); #1;
    end
    bus.val_i = 1'b0;
    gap = second - first;
    chk("cont.first",  first, LAT);
    chk("cont.gap",    gap, ITER + 2);
    chk("cont.pulses", pulses, 3);
    chk("cont.re", int'(bus.real_o), model(1000, AMP, 1'b0), 1);
    chk("cont.im", int'(bus.imag_o), model(1000, AMP, 1'b1), 1);
    n = 0;
    while (!bus.ready_o && n < 40) begin @(posedge clk); #1; n++; end
    chk("cont.idle", int'(bus.ready_o), 1);

    // Assert reset mid-computation: expect an abort with no result and outputs returned to zero.
    bus.angle_i = 16'sd3217;
    bus.val_i   = 1'b1;
    @(posedge clk); #1;
    bus.val_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort.val",   int'(bus.val_o), 0);
    chk("abort.re",    int'(bus.real_o), 0);
    chk("abort.im",    int'(bus.imag_o), 0);
    chk("abort.ready", int'(bus.ready_o), 1);
`ifdef ANGLE_TO_IQ_DROP_CNT_EN
    chk("abort.drop",  int'(drop_cnt), 0);
`endif
    pulses = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.val_o) pulses++;
    end
    chk("abort.noval", pulses, 0);

    // Random sweep over the full 16-bit range, which exercises the clamp path.
    for (int k = 0; k < 1000; k++) begin
      a = 16'($urandom_range(0, 65535));
      run_one("rnd", a, model(int'(a), AMP, 1'b0), model(int'(a), AMP, 1'b1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so that the bench cannot hang.
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
